// File: rtl/cb_sequencer_if.sv
// Bus bundle for the CB-prefix sequencer: control-unit handshake, register
// file port, memory port at (HL), ALU drive/return and flag write-back.
// The sequencer uses the slave view; its surroundings use the master view.
interface cb_sequencer_if;
    logic        start;
    logic [7:0]  opcode;
    logic [15:0] hl;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;

    logic [2:0]  reg_sel;
    logic [7:0]  reg_rdata;
    logic        reg_we;
    logic [7:0]  reg_wdata;

    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    logic [5:0]  alu_op;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [3:0]  alu_fin;
    logic [15:0] alu_o;
    logic [3:0]  alu_fout;

    logic        flags_we;
    logic [3:0]  flags_out;

    modport master (
        output start, opcode, hl, flags_in, reg_rdata, mem_rdata, mem_ack,
               alu_o, alu_fout,
        input  busy, done, reg_sel, reg_we, reg_wdata, mem_addr, mem_rd,
               mem_wr, mem_wdata, alu_op, alu_x, alu_y, alu_fin, flags_we,
               flags_out
    );

    modport slave (
        input  start, opcode, hl, flags_in, reg_rdata, mem_rdata, mem_ack,
               alu_o, alu_fout,
        output busy, done, reg_sel, reg_we, reg_wdata, mem_addr, mem_rd,
               mem_wr, mem_wdata, alu_op, alu_x, alu_y, alu_fin, flags_we,
               flags_out
    );
endinterface

// File: rtl/cb_sequencer.sv
// CB-prefix instruction sequencer. Fetches the operand from a register or
// from (HL), runs rotate/shift/swap, RES and SET through the external ALU,
// evaluates BIT locally, then writes back data and/or flags and pulses done.
module cb_sequencer (
    input  logic          clk,
    input  logic          rst_n,
    cb_sequencer_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  nextState;
    logic [7:0]  opReg;
    logic [15:0] hlReg;
    logic [7:0]  operand;
    logic [7:0]  result;
    logic [3:0]  flagRes;
    logic        firstWrite;

    logic [1:0]  group;
    logic [2:0]  bitIdx;
    logic        isMem;
    logic        isBit;
    logic [7:0]  bitMask;
    logic [7:0]  unusedAluHigh;

    assign group         = opReg[7:6];
    assign bitIdx        = opReg[5:3];
    assign isMem         = (opReg[2:0] == 3'd6);
    assign isBit         = (group == 2'b01);
    assign bitMask       = 8'h01 << bitIdx;
    assign unusedAluHigh = bus.alu_o[15:8];

    // Next-state selection; memory phases stretch until mem_ack, BIT never waits in WRITE
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = READ;
            READ:    if (!isMem || bus.mem_ack) nextState = EXEC;
            EXEC:    nextState = WRITE;
            WRITE:   if (isBit || !isMem || bus.mem_ack) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register; reset drops back to IDLE at once so every strobe dies immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Latch the instruction context, operand, result and flag result as each phase completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opReg      <= 8'h00;
            hlReg      <= 16'h0000;
            operand    <= 8'h00;
            result     <= 8'h00;
            flagRes    <= 4'h0;
            firstWrite <= 1'b0;
        end else begin
            firstWrite <= (state == EXEC);
            if (state == IDLE && bus.start) begin
                opReg <= bus.opcode;
                hlReg <= bus.hl;
            end
            if (state == READ) begin
                if (!isMem)           operand <= bus.reg_rdata;
                else if (bus.mem_ack) operand <= bus.mem_rdata;
            end
            if (state == EXEC) begin
                if (!isBit) result <= bus.alu_o[7:0];
                if (group == 2'b00)
                    flagRes <= bus.alu_fout;
                else if (isBit)
                    flagRes <= {~operand[bitIdx], 1'b0, 1'b1, bus.flags_in[0]};
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.reg_sel   = opReg[2:0];
    assign bus.mem_addr  = hlReg;
    assign bus.mem_rd    = (state == READ) && isMem;
    assign bus.mem_wr    = (state == WRITE) && isMem && !isBit;
    assign bus.reg_we    = (state == WRITE) && !isMem && !isBit;
    assign bus.reg_wdata = result;
    assign bus.mem_wdata = result;
    assign bus.flags_we  = (state == WRITE) && firstWrite && !group[1];
    assign bus.flags_out = flagRes;
    assign bus.alu_fin   = bus.flags_in;

    // ALU drive is only active in EXEC for ALU-based groups; BIT leaves the ALU idle
    always_comb begin
        bus.alu_op = 6'h00;
        bus.alu_x  = 16'h0000;
        bus.alu_y  = 16'h0000;
        if (state == EXEC && !isBit) begin
            bus.alu_x = {8'h00, operand};
            case (group)
                2'b00: begin
                    case (bitIdx)
                        3'd0:    bus.alu_op = 6'h08;
                        3'd1:    bus.alu_op = 6'h09;
                        3'd2:    bus.alu_op = 6'h0A;
                        3'd3:    bus.alu_op = 6'h0B;
                        3'd4:    bus.alu_op = 6'h10;
                        3'd5:    bus.alu_op = 6'h11;
                        3'd6:    bus.alu_op = 6'h13;
                        default: bus.alu_op = 6'h12;
                    endcase
                end
                2'b10: begin
                    bus.alu_op = 6'h04;
                    bus.alu_y  = {8'h00, ~bitMask};
                end
                default: begin
                    bus.alu_op = 6'h06;
                    bus.alu_y  = {8'h00, bitMask};
                end
            endcase
        end
    end

endmodule
